// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned SA_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Start/result handshake bundle between a requester and the serial adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEF
) ();

  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_carry;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;

  modport master (
    output i_start, i_a, i_b, i_carry,
    input  o_busy, o_done, o_sum, o_carry
  );

  modport slave (
    input  i_start, i_a, i_b, i_carry,
    output o_busy, o_done, o_sum, o_carry
  );

endinterface

// File: rtl/full_adder_v.sv
// One-bit full adder cell.
module full_adder_v (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry,
  output logic o_s,
  output logic o_carry
);

  assign o_s     = i_a ^ i_b ^ i_carry;
  assign o_carry = (i_a & i_b) | (i_a & i_carry) | (i_b & i_carry);

endmodule

// File: rtl/serial_adder_v.sv
// Bit-serial adder: one operand bit pair per clock through a single full adder.
module serial_adder_v
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             fa_s;
  logic             fa_c;

  full_adder_v u_fa (
    .i_a     (sa_q[0]),
    .i_b     (sb_q[0]),
    .i_carry (c_q),
    .o_s     (fa_s),
    .o_carry (fa_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sum_sh_d = sum_sh_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    carry_d  = carry_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          sa_d     = bus.i_a;
          sb_d     = bus.i_b;
          c_d      = bus.i_carry;
          sum_sh_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        c_d      = fa_c;
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last bit pair: publish the result straight from the adder outputs
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          carry_d = fa_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sum_sh_q <= sum_sh_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_sum   = sum_q;
  assign bus.o_carry = carry_q;

endmodule

// File: doc/serial_adder_v.md
Name: serial_adder_v

Overview:
- Bit-serial ripple adder that is the sequential stage built around the team's existing one-bit full adder cell.
- Accepts two WIDTH-bit operands and a carry-in through a start handshake.
- Feeds one operand bit pair per clock, LSB first, through a single full_adder_v instance with the carry registered between cycles.
- Returns a WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived, not overridden).

Ports:
- i_clk  input  1  clock, all state updates on the rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_start  input  1  request; sampled only when state is IDLE or DONE.
- i_a  input  WIDTH  operand A, captured on the accepted i_start edge.
- i_b  input  WIDTH  operand B, captured on the accepted i_start edge.
- i_carry  input  1  carry-in, captured on the accepted i_start edge.
- o_busy  output  1  high while a serial addition is in progress.
- o_done  output  1  one-cycle pulse when the result is valid.
- o_sum  output  WIDTH  sum result, held until the next accepted start.
- o_carry  output  1  carry-out result, held until the next accepted start.

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_rst). All outputs are registered.
- Reset values: state=IDLE, o_busy=0, o_done=0, o_sum=0, o_carry=0, counter=0, internal shift and carry registers=0.
- States: IDLE, RUN, DONE.
- IDLE: if i_start=1 at edge k, the block loads shift registers SA<=i_a, SB<=i_b, C<=i_carry and sets counter<=0, then goes to RUN; o_busy=1 from edge k. If i_start=0, it stays in IDLE.
- RUN, on each edge:
  - the full adder evaluates (SA[0], SB[0], C);
  - the sum bit shifts into SUM[WIDTH-1] while SUM shifts right;
  - C <= adder carry;
  - SA and SB shift right, zero-filled;
  - counter increments.
- RUN exit: on the edge where counter==WIDTH-1 (the WIDTH-th RUN edge, edge k+WIDTH), the block goes to DONE and sets o_sum<=final SUM, o_carry<=final carry, o_busy<=0, o_done<=1.
- Latency: o_done is high in the single cycle after edge k+WIDTH. o_busy is high for exactly WIDTH cycles.
- DONE: o_done lasts one cycle. At the next edge, if i_start=1, the block loads new operands exactly as from IDLE (back-to-back, no idle gap). Otherwise it goes to IDLE. o_done clears in either case.
- i_start while in RUN is ignored entirely; operands are not re-captured and latency is unchanged.
- Arithmetic: {o_carry,o_sum} = i_a + i_b + i_carry, modulo 2^(WIDTH+1). Overflow is not flagged separately; o_carry is the overflow.
- o_sum and o_carry stay stable from the DONE transition until the next accepted start edge. They are not cleared when returning to IDLE.
- i_rst=1 at any edge, including mid-RUN, forces all reset values on that edge. The in-flight operation is discarded and no o_done is produced. i_rst has priority over i_start.
- Operand changes on i_a, i_b, i_carry after capture have no effect.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant SA_WIDTH_DEF=4.
- One sub-module instance: the existing full_adder_v (ports i_a, i_b, i_carry, o_s, o_carry), driven by SA[0], SB[0], C. No other sub-modules.

Test Plan:
- Assert i_rst for 2 cycles, then release -> o_busy=0, o_done=0, o_sum=4'b0000, o_carry=0; idle for 5 cycles with no o_done.
- WIDTH=4, i_a=4'b0011, i_b=4'b0101, i_carry=0, pulse i_start -> o_busy high for 4 cycles, then o_done for 1 cycle with o_sum=4'b1000, o_carry=0.
- i_a=4'b1111, i_b=4'b0001, i_carry=0 -> o_sum=4'b0000, o_carry=1. Then i_a=4'b1111, i_b=4'b1111, i_carry=1 -> o_sum=4'b1111, o_carry=1.
- Start 4'b0110+4'b0011, c=0, then pulse i_start with different operands mid-RUN -> the second start is ignored, o_done arrives at the original cycle with o_sum=4'b1001, and no extra o_done follows.
- Hold i_start high through DONE with new operands 4'b0001+4'b0001, c=1 -> the second operation starts with no idle cycle; o_done pulses exactly 5 cycles apart; second result o_sum=4'b0011, o_carry=0.
- Start 4'b1010+4'b0101, assert i_rst on the 2nd RUN cycle -> all outputs reset and no o_done; a subsequent clean start of 4'b1010+4'b0101 with c=0 gives o_sum=4'b1111, o_carry=0.
